fdd_track_writeback: RTL and testbench

//  Write-back stage for the floppy track buffer (14-bit dpram, 13 x 512-byte sectors).

---
 rtl/fdd_track_writeback.sv | 165 ++++++++++++++++
 tb/tb_fdd_track_writeback.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_track_writeback.sv
// fdd_track_writeback
// Write-back stage for the floppy track buffer. Tracks which 512-byte sectors
// the disk controller has modified and streams each dirty sector back to the
// SD image over the hps_io VD0 write handshake, one sector at a time.
// A flush starts when the head leaves the buffered track, when the buffer has
// been idle for IDLE_CYC cycles, or on an explicit flush_req pulse.
module fdd_track_writeback #(
   parameter int SECS     = 13,
   parameter int IDLE_CYC = 1431818
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic [5:0]      track,
   input  logic [5:0]      buf_track,
   input  logic            fd_write_disk,
   input  logic [13:0]     fd_track_addr,
   input  logic            img_mounted,
   input  logic            img_readonly,
   input  logic            flush_req,
   input  logic            sd_ack,
   output logic [31:0]     sd_lba,
   output logic            sd_wr,
   output logic [3:0]      buf_sec,
   output logic            wb_busy,
   output logic            cpu_wait,
   output logic [SECS-1:0] dirty
);

   localparam int TW = $clog2(IDLE_CYC + 1);

   typedef enum logic [1:0] {IDLE, PICK, REQ, XFER} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic            old_ack;
   logic            mounted;
   logic            abort;

   logic [3:0]      wr_sec;
   logic            wr_ok;
   logic            ack_rise;
   logic            ack_fall;
   logic [SECS-1:0] wr_mask;
   logic [SECS-1:0] dirty_nxt;
   logic [3:0]      pick_idx;
   logic [31:0]     t32;
   logic [31:0]     i32;
   logic [31:0]     pick_lba;

   assign wr_sec   = fd_track_addr[12:9];
   assign wr_ok    = fd_write_disk && mounted && !img_readonly &&
                     ({28'd0, wr_sec} < 32'(SECS));
   assign ack_rise = sd_ack && !old_ack;
   assign ack_fall = !sd_ack && old_ack;

   // Next dirty mask: ack clears the sector in flight, a same-cycle controller
   // write to that sector wins, and a new mount discards everything.
   always_comb begin
      wr_mask   = '0;
      dirty_nxt = dirty;
      for (int i = 0; i < SECS; i++) begin
         if (wr_ok && wr_sec == 4'(i))
            wr_mask[i] = 1'b1;
         if (state == REQ && ack_rise && buf_sec == 4'(i))
            dirty_nxt[i] = 1'b0;
      end
      dirty_nxt = dirty_nxt | wr_mask;
      if (img_mounted)
         dirty_nxt = '0;
   end

   // Lowest dirty sector and its LBA; SECS=13 folds to (t<<3)+(t<<2)+t.
   always_comb begin
      pick_idx = 4'd0;
      for (int i = SECS - 1; i >= 0; i--) begin
         if (dirty[i])
            pick_idx = 4'(i);
      end
      t32      = {26'd0, buf_track};
      i32      = {28'd0, pick_idx};
      pick_lba = (SECS == 13) ? ((t32 << 3) + (t32 << 2) + t32 + i32)
                              : (t32 * 32'(SECS) + i32);
   end

   // Idle timer: reloaded by any buffer write, counts down only while dirty data waits.
   always_ff @(posedge clk_sys) begin
      if (reset)
         timer <= TW'(IDLE_CYC);
      else if (fd_write_disk)
         timer <= TW'(IDLE_CYC);
      else if (state == IDLE && dirty != '0 && timer != '0)
         timer <= timer - 1'b1;
   end

   // Flush sequencer with registered handshake outputs and dirty bookkeeping.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= IDLE;
         sd_wr    <= 1'b0;
         sd_lba   <= 32'd0;
         buf_sec  <= 4'd0;
         wb_busy  <= 1'b0;
         cpu_wait <= 1'b0;
         dirty    <= '0;
         old_ack  <= 1'b0;
         mounted  <= 1'b0;
         abort    <= 1'b0;
      end else begin
         dirty   <= dirty_nxt;
         old_ack <= sd_ack;
         if (img_mounted)
            mounted <= 1'b1;

         if (img_mounted && state != XFER) begin
            state    <= IDLE;
            sd_wr    <= 1'b0;
            cpu_wait <= 1'b0;
            wb_busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (dirty != '0 && (track != buf_track || timer == '0 || flush_req)) begin
                     state   <= PICK;
                     wb_busy <= 1'b1;
                  end
               end
               PICK: begin
                  if (dirty == '0) begin
                     state   <= IDLE;
                     wb_busy <= 1'b0;
                  end else begin
                     buf_sec  <= pick_idx;
                     sd_lba   <= pick_lba;
                     sd_wr    <= 1'b1;
                     cpu_wait <= 1'b1;
                     state    <= REQ;
                  end
               end
               REQ: begin
                  if (ack_rise) begin
                     sd_wr <= 1'b0;
                     state <= XFER;
                  end
               end
               XFER: begin
                  if (img_mounted)
                     abort <= 1'b1;
                  if (ack_fall) begin
                     cpu_wait <= 1'b0;
                     if (abort || img_mounted) begin
                        state   <= IDLE;
                        wb_busy <= 1'b0;
                        abort   <= 1'b0;
                     end else begin
                        state <= PICK;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fdd_track_writeback.sv
// tb_fdd_track_writeback
// Directed bench for the track write-back stage with a short idle timeout.
module tb_fdd_track_writeback;

   localparam int SECS     = 13;
   localparam int IDLE_CYC = 100;

   logic            clk_sys;
   logic            reset;
   logic [5:0]      track;
   logic [5:0]      buf_track;
   logic            fd_write_disk;
   logic [13:0]     fd_track_addr;
   logic            img_mounted;
   logic            img_readonly;
   logic            flush_req;
   logic            sd_ack;
   logic [31:0]     sd_lba;
   logic            sd_wr;
   logic [3:0]      buf_sec;
   logic            wb_busy;
   logic            cpu_wait;
   logic [SECS-1:0] dirty;

   int passes = 0;
   int total  = 0;

   fdd_track_writeback #(.SECS(SECS), .IDLE_CYC(IDLE_CYC)) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .track         (track),
      .buf_track     (buf_track),
      .fd_write_disk (fd_write_disk),
      .fd_track_addr (fd_track_addr),
      .img_mounted   (img_mounted),
      .img_readonly  (img_readonly),
      .flush_req     (flush_req),
      .sd_ack        (sd_ack),
      .sd_lba        (sd_lba),
      .sd_wr         (sd_wr),
      .buf_sec       (buf_sec),
      .wb_busy       (wb_busy),
      .cpu_wait      (cpu_wait),
      .dirty         (dirty)
   );

   // Free-running 100 MHz-style bench clock
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One-cycle controller write into the track buffer
   task automatic applyStimulus(input logic [13:0] addr);
      fd_write_disk = 1'b1;
      fd_track_addr = addr;
      tick();
      fd_write_disk = 1'b0;
   endtask

   // Pulse a single-cycle flush request
   task automatic pulseFlush();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
   endtask

   // hps_io acknowledge: rise, hold, fall; leaves the FSM in PICK
   task automatic ackPulse(input string tag);
      sd_ack = 1'b1;
      tick();
      checkOutput({tag, "_wr_after_rise"}, 32'(sd_wr), 32'd0);
      checkOutput({tag, "_wait_xfer"}, 32'(cpu_wait), 32'd1);
      tick();
      sd_ack = 1'b0;
      tick();
      checkOutput({tag, "_wait_after_fall"}, 32'(cpu_wait), 32'd0);
   endtask

   logic [31:0] exp_lba [3];

   initial begin
      reset         = 1'b1;
      track         = 6'd3;
      buf_track     = 6'd3;
      fd_write_disk = 1'b0;
      fd_track_addr = 14'd0;
      img_mounted   = 1'b0;
      img_readonly  = 1'b0;
      flush_req     = 1'b0;
      sd_ack        = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_sd_wr",    32'(sd_wr),    32'd0);
      checkOutput("rst_sd_lba",   sd_lba,        32'd0);
      checkOutput("rst_buf_sec",  32'(buf_sec),  32'd0);
      checkOutput("rst_wb_busy",  32'(wb_busy),  32'd0);
      checkOutput("rst_cpu_wait", 32'(cpu_wait), 32'd0);
      checkOutput("rst_dirty",    32'(dirty),    32'd0);

      // Before any mount, writes must not mark sectors
      applyStimulus(14'h0A05);
      checkOutput("nomount_dirty", 32'(dirty), 32'd0);

      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;

      // Head leaves buffered track 3: sector 5 written at LBA 3*13+5 = 44
      applyStimulus(14'h0A05);
      checkOutput("t1_dirty", 32'(dirty), 32'h020);
      track = 6'd4;
      tick();
      checkOutput("t1_busy_pick", 32'(wb_busy), 32'd1);
      checkOutput("t1_wr_pick",   32'(sd_wr),   32'd0);
      tick();
      checkOutput("t1_wr_req",    32'(sd_wr),    32'd1);
      checkOutput("t1_lba",       sd_lba,        32'd44);
      checkOutput("t1_buf_sec",   32'(buf_sec),  32'd5);
      checkOutput("t1_wait_req",  32'(cpu_wait), 32'd1);
      ackPulse("t1");
      checkOutput("t1_dirty_clr", 32'(dirty),   32'd0);
      checkOutput("t1_busy_fall", 32'(wb_busy), 32'd1);
      tick();
      checkOutput("t1_busy_idle", 32'(wb_busy), 32'd0);
      track = 6'd3;

      // Sectors 0, 7, 12 flushed lowest first: LBAs 39, 46, 51
      applyStimulus(14'h0000);
      applyStimulus(14'h0E00);
      applyStimulus(14'h1800);
      checkOutput("t2_dirty", 32'(dirty), 32'h1081);
      checkOutput("t2_wait_idle", 32'(cpu_wait), 32'd0);
      pulseFlush();
      checkOutput("t2_busy", 32'(wb_busy), 32'd1);
      checkOutput("t2_wait_pick", 32'(cpu_wait), 32'd0);
      exp_lba[0] = 32'd39;
      exp_lba[1] = 32'd46;
      exp_lba[2] = 32'd51;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("t2_wr_%0d", k),   32'(sd_wr),    32'd1);
         checkOutput($sformatf("t2_lba_%0d", k),  sd_lba,        exp_lba[k]);
         checkOutput($sformatf("t2_wait_%0d", k), 32'(cpu_wait), 32'd1);
         ackPulse($sformatf("t2_%0d", k));
      end
      tick();
      checkOutput("t2_busy_end",  32'(wb_busy), 32'd0);
      checkOutput("t2_dirty_end", 32'(dirty),   32'd0);

      // Idle timeout: sd_wr rises exactly IDLE_CYC+2 edges after the strobe edge
      applyStimulus(14'h0200);
      repeat (IDLE_CYC) tick();
      checkOutput("t3_busy_early", 32'(wb_busy), 32'd0);
      tick();
      checkOutput("t3_busy_pick", 32'(wb_busy), 32'd1);
      checkOutput("t3_wr_pick",   32'(sd_wr),   32'd0);
      tick();
      checkOutput("t3_wr_req", 32'(sd_wr), 32'd1);
      checkOutput("t3_lba",    sd_lba,     32'd40);
      ackPulse("t3");
      tick();
      checkOutput("t3_busy_end", 32'(wb_busy), 32'd0);

      // Write lands on the ack-rise cycle for the same sector: written twice
      applyStimulus(14'h0400);
      pulseFlush();
      tick();
      checkOutput("t4_lba_a", sd_lba, 32'd41);
      sd_ack        = 1'b1;
      fd_write_disk = 1'b1;
      fd_track_addr = 14'h0400;
      tick();
      fd_write_disk = 1'b0;
      checkOutput("t4_dirty_kept", 32'(dirty), 32'h004);
      checkOutput("t4_wr_low",     32'(sd_wr), 32'd0);
      tick();
      sd_ack = 1'b0;
      tick();
      tick();
      checkOutput("t4_wr_again",  32'(sd_wr),   32'd1);
      checkOutput("t4_lba_b",     sd_lba,       32'd41);
      checkOutput("t4_buf_sec_b", 32'(buf_sec), 32'd2);
      ackPulse("t4");
      checkOutput("t4_dirty_end", 32'(dirty), 32'd0);
      tick();
      checkOutput("t4_busy_end", 32'(wb_busy), 32'd0);

      // Read-only image and out-of-range sector are ignored
      img_readonly = 1'b1;
      applyStimulus(14'h0600);
      img_readonly = 1'b0;
      checkOutput("t5_ro_dirty", 32'(dirty), 32'd0);
      applyStimulus(14'h1A00);
      checkOutput("t5_sec13_dirty", 32'(dirty), 32'd0);
      pulseFlush();
      checkOutput("t5_no_flush", 32'(wb_busy), 32'd0);

      // New mount while a request is outstanding abandons it
      applyStimulus(14'h0800);
      pulseFlush();
      tick();
      checkOutput("t6_wr_req", 32'(sd_wr), 32'd1);
      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
      checkOutput("t6_wr_drop",  32'(sd_wr),    32'd0);
      checkOutput("t6_dirty",    32'(dirty),    32'd0);
      checkOutput("t6_busy",     32'(wb_busy),  32'd0);
      checkOutput("t6_wait",     32'(cpu_wait), 32'd0);
      tick();
      tick();
      checkOutput("t6_stay_idle", 32'(sd_wr), 32'd0);

      // Reset in the middle of a transfer
      applyStimulus(14'h0C00);
      pulseFlush();
      tick();
      checkOutput("t6r_lba", sd_lba, 32'd45);
      sd_ack = 1'b1;
      tick();
      checkOutput("t6r_wait_xfer", 32'(cpu_wait), 32'd1);
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      sd_ack = 1'b0;
      checkOutput("t6r_sd_wr",    32'(sd_wr),    32'd0);
      checkOutput("t6r_sd_lba",   sd_lba,        32'd0);
      checkOutput("t6r_buf_sec",  32'(buf_sec),  32'd0);
      checkOutput("t6r_wb_busy",  32'(wb_busy),  32'd0);
      checkOutput("t6r_cpu_wait", 32'(cpu_wait), 32'd0);
      checkOutput("t6r_dirty",    32'(dirty),    32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
